// File: rtl/instr_loader.sv
// Instruction loader: assembles a little-endian byte stream into 32-bit words
// and writes them to instruction memory while holding the core in reset.
module instr_loader #(
  parameter int ADDR_WIDTH_POW      = 6,
  parameter int INSTR_MEM_DEPTH_POW = 10
) (
  input  logic                                clk_in,
  input  logic                                reset,
  input  logic                                start_in,
  input  logic [INSTR_MEM_DEPTH_POW:0]        word_count_in,
  input  logic                                abort_in,
  input  logic                                byte_valid_in,
  input  logic [7:0]                          byte_data_in,
  output logic                                byte_ready_out,
  output logic                                mem_we_out,
  output logic [(1 << ADDR_WIDTH_POW)-1:0]    mem_addr_out,
  output logic [31:0]                         mem_data_out,
  output logic                                core_reset_out,
  output logic                                busy_out,
  output logic                                done_out,
  output logic                                error_out
);

  localparam int ADDR_WIDTH = 1 << ADDR_WIDTH_POW;
  localparam int CNT_W      = INSTR_MEM_DEPTH_POW + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MAX_COUNT = {1'b1, {INSTR_MEM_DEPTH_POW{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [CNT_W-1:0]        word_idx_q, word_idx_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [31:0]             word_q, word_d;
  logic                    error_q, error_d;
  logic                    core_reset_q, core_reset_d;

  logic                    byte_ready_q, byte_ready_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]             mem_data_q, mem_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    count_ok_s;

  assign count_ok_s = (word_count_in != CNT_ZERO) && (word_count_in <= MAX_COUNT);

  // Next-state logic; outputs are precomputed from the next state so they leave flops.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    error_d      = error_q;
    core_reset_d = core_reset_q;

    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          if (count_ok_s) begin
            count_d      = word_count_in;
            word_idx_d   = CNT_ZERO;
            byte_idx_d   = 2'd0;
            word_d       = 32'd0;
            error_d      = 1'b0;
            core_reset_d = 1'b1;
            state_d      = S_RECV;
          end else begin
            error_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RECV: begin
        if (abort_in) begin
          state_d      = S_IDLE;
          byte_idx_d   = 2'd0;
          word_d       = 32'd0;
          error_d      = 1'b1;
          core_reset_d = 1'b1;
        end else if (byte_valid_in) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = byte_data_in;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_RECV;
          end
        end else begin
          state_d = S_RECV;
        end
      end
      S_WRITE: begin
        if (abort_in) begin
          state_d      = S_IDLE;
          byte_idx_d   = 2'd0;
          word_d       = 32'd0;
          error_d      = 1'b1;
          core_reset_d = 1'b1;
        end else begin
          word_idx_d = word_idx_q + CNT_ONE;
          if ((word_idx_q + CNT_ONE) == count_q) begin
            // Release the core as DONE begins so the pulse and the release coincide.
            state_d      = S_DONE;
            core_reset_d = 1'b0;
          end else begin
            state_d = S_RECV;
          end
        end
      end
      S_DONE: begin
        core_reset_d = 1'b0;
        state_d      = S_IDLE;
      end
      default: begin
        state_d      = S_IDLE;
        byte_idx_d   = 2'd0;
        word_d       = 32'd0;
        core_reset_d = 1'b1;
      end
    endcase

    byte_ready_d = (state_d == S_RECV);
    mem_we_d     = (state_d == S_WRITE);
    busy_d       = (state_d == S_RECV) || (state_d == S_WRITE);
    done_d       = (state_d == S_DONE);
    if (state_d == S_WRITE) begin
      mem_addr_d = ADDR_WIDTH'({word_idx_d, 2'b00});
      mem_data_d = word_d;
    end else begin
      mem_addr_d = {ADDR_WIDTH{1'b0}};
      mem_data_d = 32'd0;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      count_q      <= CNT_ZERO;
      word_idx_q   <= CNT_ZERO;
      byte_idx_q   <= 2'd0;
      word_q       <= 32'd0;
      error_q      <= 1'b0;
      core_reset_q <= 1'b1;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_WIDTH{1'b0}};
      mem_data_q   <= 32'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      error_q      <= error_d;
      core_reset_q <= core_reset_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign byte_ready_out = byte_ready_q;
  assign mem_we_out     = mem_we_q;
  assign mem_addr_out   = mem_addr_q;
  assign mem_data_out   = mem_data_q;
  assign core_reset_out = core_reset_q;
  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign error_out      = error_q;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected writes are queued as words are
// streamed and retired by a monitor whenever the loader strobes the memory.
module tb_instr_loader;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        start_in;
  logic [10:0] word_count_in;
  logic        abort_in;
  logic        byte_valid_in;
  logic [7:0]  byte_data_in;
  logic        byte_ready_out;
  logic        mem_we_out;
  logic [63:0] mem_addr_out;
  logic [31:0] mem_data_out;
  logic        core_reset_out;
  logic        busy_out;
  logic        done_out;
  logic        error_out;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [63:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  instr_loader dut (
    .clk_in         (clk_in),
    .reset          (reset),
    .start_in       (start_in),
    .word_count_in  (word_count_in),
    .abort_in       (abort_in),
    .byte_valid_in  (byte_valid_in),
    .byte_data_in   (byte_data_in),
    .byte_ready_out (byte_ready_out),
    .mem_we_out     (mem_we_out),
    .mem_addr_out   (mem_addr_out),
    .mem_data_out   (mem_data_out),
    .core_reset_out (core_reset_out),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .error_out      (error_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: retire queued writes, count done pulses.
  always @(negedge clk_in) begin
    if (!reset && mem_we_out) begin
      wr_cnt++;
      check_eq("ready_in_write", byte_ready_out, 1'b0);
      if (exp_addr_q.size() == 0) begin
        check_eq("unexpected_we", mem_we_out, 1'b0);
      end else begin
        check_eq("wr_addr", mem_addr_out, exp_addr_q.pop_front());
        check_eq("wr_data", mem_data_out, exp_data_q.pop_front());
      end
    end
    if (!reset && done_out) done_cnt++;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic start_load(input logic [10:0] cnt);
    start_in      = 1'b1;
    word_count_in = cnt;
    tick();
    start_in      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc = 1'b0;
    byte_valid_in = 1'b1;
    byte_data_in  = b;
    for (int n = 0; n < 50 && !acc; n++) begin
      acc = byte_ready_out;
      tick();
    end
    byte_valid_in = 1'b0;
    if (!acc) check_eq("byte_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max, input logic [63:0] addr);
    exp_addr_q.push_back(addr);
    exp_data_q.push_back(w);
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, gap_max)) tick();
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic wait_done();
    for (int n = 0; n < 50 && !done_out; n++) tick();
    check_eq("done_seen", done_out, 1'b1);
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_ready"}, byte_ready_out, 1'b0);
    check_eq({tag, "_we"}, mem_we_out, 1'b0);
    check_eq({tag, "_addr"}, mem_addr_out, 64'd0);
    check_eq({tag, "_data"}, mem_data_out, 32'd0);
    check_eq({tag, "_busy"}, busy_out, 1'b0);
    check_eq({tag, "_done"}, done_out, 1'b0);
    check_eq({tag, "_err"}, error_out, 1'b0);
    check_eq({tag, "_coreRst"}, core_reset_out, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w0, d0;
    logic [31:0] wa, wb;
    reset = 1'b1; start_in = 1'b0; word_count_in = 11'd0; abort_in = 1'b0;
    byte_valid_in = 1'b0; byte_data_in = 8'd0;
    repeat (3) tick();
    check_reset_outs("rst");
    reset = 1'b0;
    tick();

    // Single word, back-to-back bytes
    start_load(11'd1);
    check_eq("t1_busy", busy_out, 1'b1);
    check_eq("t1_coreRst", core_reset_out, 1'b1);
    exp_addr_q.push_back(64'd0);
    exp_data_q.push_back(32'h0000_0013);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check_eq("t1_latency_we", mem_we_out, 1'b1);
    tick();
    check_eq("t1_done", done_out, 1'b1);
    check_eq("t1_done_coreRst", core_reset_out, 1'b0);
    check_eq("t1_done_busy", busy_out, 1'b0);
    tick();
    check_eq("t1_idle_done", done_out, 1'b0);
    check_eq("t1_idle_coreRst", core_reset_out, 1'b0);

    // Three words with random valid gaps
    w0 = wr_cnt; d0 = done_cnt;
    start_load(11'd3);
    for (int i = 0; i < 3; i++) send_word($urandom, 3, 64'(i * 4));
    wait_done();
    tick();
    check_eq("t2_writes", wr_cnt - w0, 3);
    check_eq("t2_dones", done_cnt - d0, 1);
    check_eq("t2_err", error_out, 1'b0);

    // Rejected counts
    w0 = wr_cnt;
    start_load(11'd1025);
    check_eq("t3_err1025", error_out, 1'b1);
    check_eq("t3_busy1025", busy_out, 1'b0);
    check_eq("t3_coreRst1025", core_reset_out, 1'b0);
    repeat (3) tick();
    check_eq("t3_busy1025_later", busy_out, 1'b0);
    start_load(11'd1);
    check_eq("t3_err_cleared", error_out, 1'b0);
    send_word(32'hDEAD_BEEF, 0, 64'd0);
    wait_done();
    tick();
    w0 = wr_cnt;
    start_load(11'd0);
    check_eq("t3_err0", error_out, 1'b1);
    check_eq("t3_busy0", busy_out, 1'b0);
    repeat (3) tick();
    check_eq("t3_writes0", wr_cnt - w0, 0);

    // Abort after six bytes of a two-word load
    w0 = wr_cnt; d0 = done_cnt;
    start_load(11'd2);
    send_word(32'h0403_0201, 1, 64'd0);
    send_byte(8'h55); send_byte(8'h66);
    abort_in = 1'b1;
    tick();
    abort_in = 1'b0;
    check_eq("t4_busy", busy_out, 1'b0);
    check_eq("t4_err", error_out, 1'b1);
    check_eq("t4_coreRst", core_reset_out, 1'b1);
    repeat (6) tick();
    check_eq("t4_writes", wr_cnt - w0, 1);
    check_eq("t4_dones", done_cnt - d0, 0);

    // Asynchronous reset mid-word
    w0 = wr_cnt;
    start_load(11'd2);
    send_byte(8'hA1); send_byte(8'hA2);
    #2 reset = 1'b1;
    #1 check_reset_outs("arst");
    tick();
    reset = 1'b0;
    byte_valid_in = 1'b1;
    byte_data_in  = 8'hAA;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("t5_no_ready", byte_ready_out, 1'b0);
    end
    byte_valid_in = 1'b0;
    check_eq("t5_writes", wr_cnt - w0, 0);

    // start_in ignored in RECV and DONE
    w0 = wr_cnt; d0 = done_cnt;
    wa = 32'h1122_3344; wb = 32'h5566_7788;
    start_load(11'd2);
    exp_addr_q.push_back(64'd0);
    exp_data_q.push_back(wa);
    send_byte(wa[7:0]);
    start_load(11'd1);
    send_byte(wa[15:8]); send_byte(wa[23:16]); send_byte(wa[31:24]);
    send_word(wb, 1, 64'd4);
    wait_done();
    start_load(11'd1);
    check_eq("t6_busy_after_done", busy_out, 1'b0);
    check_eq("t6_coreRst", core_reset_out, 1'b0);
    repeat (4) tick();
    check_eq("t6_writes", wr_cnt - w0, 2);
    check_eq("t6_dones", done_cnt - d0, 1);

    check_eq("sb_empty", exp_addr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
